// File: rtl/lpif_tx_stb_mrk_seq.sv
// TX-side LPIF link sequencer: OFFLINE -> SYNC -> ONLINE bring-up plus
// strobe/marker userbit generation for the x4 asym2 full-rate concat datapath.
module lpif_tx_stb_mrk_seq #(
  parameter int STB_W      = 8,
  parameter int MRK_PERIOD = 2,
  parameter int SYNC_BEATS = 32,
  parameter int SYNC_W     = 8
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  input  logic             tx_online,
  input  logic             m_gen2_mode,
  input  logic [STB_W-1:0] cfg_stb_interval,
  input  logic             resync_req,
  output logic             tx_stb_userbit,
  output logic             tx_mrk_userbit,
  output logic             tx_link_up,
  output logic             tx_pop_en,
  output logic [1:0]       seq_state
);

  localparam int MW = (MRK_PERIOD > 1) ? $clog2(MRK_PERIOD) : 1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SYNC = 2'd1,
    ST_ON   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [STB_W-1:0]  stb_cnt_q, stb_cnt_d;
  logic [MW-1:0]     mrk_cnt_q, mrk_cnt_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic              gen2_q, gen2_d;
  logic [STB_W-1:0]  intv_q, intv_d;

  logic [MW-1:0]     mrk_last;
  logic [SYNC_W-1:0] sync_last;
  logic [STB_W-1:0]  stb_nxt;
  logic [MW-1:0]     mrk_nxt;
  logic              start;

  assign mrk_last  = gen2_q ? MW'(MRK_PERIOD - 1) : '0;
  assign sync_last = SYNC_W'(SYNC_BEATS - 1);
  assign stb_nxt   = (stb_cnt_q == intv_q - STB_W'(1)) ? '0 : stb_cnt_q + STB_W'(1);
  assign mrk_nxt   = (mrk_cnt_q == mrk_last) ? '0 : mrk_cnt_q + MW'(1);

  always_comb begin
    state_d    = state_q;
    stb_cnt_d  = stb_cnt_q;
    mrk_cnt_d  = mrk_cnt_q;
    sync_cnt_d = sync_cnt_q;
    gen2_d     = gen2_q;
    intv_d     = intv_q;
    start      = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (tx_online) start = 1'b1;
      end
      ST_SYNC: begin
        if (!tx_online) begin
          state_d    = ST_OFF;
          stb_cnt_d  = '0;
          mrk_cnt_d  = '0;
          sync_cnt_d = '0;
        end else begin
          stb_cnt_d  = stb_nxt;
          mrk_cnt_d  = mrk_nxt;
          sync_cnt_d = (sync_cnt_q == sync_last) ? sync_cnt_q : sync_cnt_q + SYNC_W'(1);
          // Leave SYNC only on a marker-group boundary so ONLINE starts a fresh group.
          if (sync_cnt_q == sync_last && mrk_cnt_q == mrk_last) state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!tx_online) begin
          state_d    = ST_OFF;
          stb_cnt_d  = '0;
          mrk_cnt_d  = '0;
          sync_cnt_d = '0;
        end else if (resync_req) begin
          start = 1'b1;
        end else begin
          stb_cnt_d = stb_nxt;
          mrk_cnt_d = mrk_nxt;
        end
      end
      default: begin
        state_d    = ST_OFF;
        stb_cnt_d  = '0;
        mrk_cnt_d  = '0;
        sync_cnt_d = '0;
      end
    endcase
    if (start) begin
      state_d    = ST_SYNC;
      stb_cnt_d  = '0;
      mrk_cnt_d  = '0;
      sync_cnt_d = '0;
      gen2_d     = m_gen2_mode;
      intv_d     = (cfg_stb_interval == '0) ? STB_W'(1) : cfg_stb_interval;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q    <= ST_OFF;
      stb_cnt_q  <= '0;
      mrk_cnt_q  <= '0;
      sync_cnt_q <= '0;
      gen2_q     <= 1'b0;
      intv_q     <= STB_W'(1);
    end else begin
      state_q    <= state_d;
      stb_cnt_q  <= stb_cnt_d;
      mrk_cnt_q  <= mrk_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      gen2_q     <= gen2_d;
      intv_q     <= intv_d;
    end
  end

  logic active;
  assign active         = (state_q == ST_SYNC) || (state_q == ST_ON);
  assign tx_stb_userbit = active && (stb_cnt_q == '0);
  assign tx_mrk_userbit = active && (mrk_cnt_q == mrk_last);
  assign tx_link_up     = (state_q == ST_ON);
  assign tx_pop_en      = tx_link_up;
  assign seq_state      = state_q;

endmodule

// File: tb/tb_lpif_tx_stb_mrk_seq.sv
// Bench for lpif_tx_stb_mrk_seq: directed vector table, hand sequences and
// randomized traffic against a beat-index reference model (two SYNC_BEATS variants).
module tb_lpif_tx_stb_mrk_seq;
  localparam int MRK = 2;

  logic clk_wr = 1'b0;
  logic rst_wr, tx_online, m_gen2_mode, resync_req;
  logic [7:0] cfg_stb_interval;
  logic stb [2], mrk [2], up [2], pop [2];
  logic [1:0] st [2];

  int n_cmp = 0, n_bad = 0;

  always #5 clk_wr = ~clk_wr;

  lpif_tx_stb_mrk_seq #(.STB_W(8), .MRK_PERIOD(MRK), .SYNC_BEATS(32), .SYNC_W(8)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .tx_online(tx_online), .m_gen2_mode(m_gen2_mode),
    .cfg_stb_interval(cfg_stb_interval), .resync_req(resync_req),
    .tx_stb_userbit(stb[0]), .tx_mrk_userbit(mrk[0]), .tx_link_up(up[0]),
    .tx_pop_en(pop[0]), .seq_state(st[0]));

  lpif_tx_stb_mrk_seq #(.STB_W(8), .MRK_PERIOD(MRK), .SYNC_BEATS(3), .SYNC_W(8)) dut3 (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .tx_online(tx_online), .m_gen2_mode(m_gen2_mode),
    .cfg_stb_interval(cfg_stb_interval), .resync_req(resync_req),
    .tx_stb_userbit(stb[1]), .tx_mrk_userbit(mrk[1]), .tx_link_up(up[1]),
    .tx_pop_en(pop[1]), .seq_state(st[1]));

  // Reference model: t = beats since the last SYNC entry; everything else follows from it.
  int sb [2] = '{32, 3};
  bit m_act [2] = '{0, 0};
  int m_t [2], m_intv [2], m_mp [2];

  function automatic bit m_online(int d);
    int first_on;
    first_on = ((sb[d] + m_mp[d] - 1) / m_mp[d]) * m_mp[d];
    return m_act[d] && (m_t[d] >= first_on);
  endfunction

  function automatic logic [5:0] m_exp(int d);
    logic [1:0] s;
    bit sb_, mk, u;
    s   = !m_act[d] ? 2'd0 : (m_online(d) ? 2'd2 : 2'd1);
    sb_ = m_act[d] && (m_t[d] % m_intv[d] == 0);
    mk  = m_act[d] && (m_t[d] % m_mp[d] == m_mp[d] - 1);
    u   = m_online(d);
    return {s, sb_, mk, u, u};
  endfunction

  task automatic m_edge();
    for (int d = 0; d < 2; d++) begin
      bit was_on;
      was_on = m_online(d);
      if (rst_wr) m_act[d] = 0;
      else if (!m_act[d] || (was_on && tx_online && resync_req)) begin
        if (tx_online) begin
          m_act[d]  = 1;
          m_t[d]    = 0;
          m_intv[d] = (cfg_stb_interval == 0) ? 1 : int'(cfg_stb_interval);
          m_mp[d]   = m_gen2_mode ? MRK : 1;
        end
      end else if (!tx_online) m_act[d] = 0;
      else m_t[d]++;
    end
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] obs(int d);
    return {st[d], stb[d], mrk[d], up[d], pop[d]};
  endfunction

  task automatic step();
    @(posedge clk_wr);
    m_edge();
    #1;
    chk("model_sb32", 8'(obs(0)), 8'(m_exp(0)));
    chk("model_sb3", 8'(obs(1)), 8'(m_exp(1)));
  endtask

  task automatic drive(bit r, bit on, bit g2, logic [7:0] iv, bit rq);
    rst_wr = r; tx_online = on; m_gen2_mode = g2; cfg_stb_interval = iv; resync_req = rq;
  endtask

  // Wait for the next strobe then count beats to the following one; -1 on timeout.
  task automatic strobe_gap(output int g);
    int n;
    g = -1;
    n = 0;
    while (stb[0] !== 1'b1 && n < 20) begin step(); n++; end
    if (stb[0] !== 1'b1) return;
    step();
    for (int k = 1; k <= 20; k++) begin
      if (stb[0] === 1'b1) begin g = k; return; end
      step();
    end
  endtask

  task automatic wait_up(output int beats);
    beats = -1;
    for (int k = 0; k < 100; k++) begin
      if (up[0] === 1'b1) begin beats = k; return; end
      step();
    end
  endtask

  typedef struct {
    bit r, on, g2, rq;
    logic [7:0] iv;
    logic [1:0] st;
    bit stb, mrk, up;
  } vec_t;

  function automatic vec_t mkv(bit r, bit on, bit g2, logic [7:0] iv, bit rq,
                               logic [1:0] s, bit sb_, bit mk, bit u);
    vec_t v;
    v.r = r; v.on = on; v.g2 = g2; v.iv = iv; v.rq = rq;
    v.st = s; v.stb = sb_; v.mrk = mk; v.up = u;
    return v;
  endfunction

  initial begin
    vec_t tbl [12];
    int g, b;
    tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 1, 4, 1, 0, 0, 0, 0);  // resync ignored in OFFLINE
    tbl[2]  = mkv(0, 1, 1, 4, 0, 1, 1, 0, 0);  // SYNC one cycle after sampling edge
    tbl[3]  = mkv(0, 1, 0, 9, 1, 1, 0, 1, 0);  // cfg/resync ignored in SYNC
    tbl[4]  = mkv(0, 1, 0, 9, 0, 1, 0, 0, 0);
    tbl[5]  = mkv(0, 1, 1, 4, 0, 1, 0, 1, 0);
    tbl[6]  = mkv(0, 1, 1, 4, 0, 1, 1, 0, 0);  // beat 4: strobe again
    tbl[7]  = mkv(0, 0, 1, 4, 0, 0, 0, 0, 0);  // drop mid-SYNC
    tbl[8]  = mkv(0, 1, 0, 0, 0, 1, 1, 1, 0);  // interval 0, Gen1
    tbl[9]  = mkv(0, 1, 0, 0, 0, 1, 1, 1, 0);
    tbl[10] = mkv(0, 1, 0, 0, 0, 1, 1, 1, 0);
    tbl[11] = mkv(1, 1, 0, 0, 0, 0, 0, 0, 0);  // reset mid-SYNC
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r, tbl[i].on, tbl[i].g2, tbl[i].iv, tbl[i].rq);
      step();
      chk($sformatf("tbl%0d", i), {4'd0, st[0], stb[0], mrk[0], up[0]},
          {4'd0, tbl[i].st, tbl[i].stb, tbl[i].mrk, tbl[i].up});
    end

    // Bring-up: ONLINE at beat 32 (SB=32) and beat 4 (SB=3), both on marker-low beats.
    drive(0, 1, 1, 4, 0);
    step();
    for (b = 0; b < 40; b++) begin
      if (b == 3)  chk("sb3_last_sync", {6'd0, st[1]}, 8'd1);
      if (b == 4)  chk("sb3_first_on", {6'd0, up[1], mrk[1]}, 8'b10);
      if (b == 31) chk("sb32_last_sync", {6'd0, st[0]}, 8'd1);
      if (b == 32) chk("sb32_first_on", {6'd0, up[0], mrk[0]}, 8'b10);
      step();
    end

    // Config change during ONLINE is not seen until the next SYNC entry.
    cfg_stb_interval = 7;
    strobe_gap(g);
    chk("gap_still_4", 8'(g), 8'd4);
    resync_req = 1;
    step();
    resync_req = 0;
    chk("resync_state", {5'd0, st[0], up[0]}, {5'd0, 2'd1, 1'b0});
    chk("resync_stb", {7'd0, stb[0]}, 8'd1);
    step();
    strobe_gap(g);
    chk("gap_now_7", 8'(g), 8'd7);
    wait_up(g);
    chk("relink_up", {7'd0, up[0]}, 8'd1);

    // Drop tx_online together with resync_req in ONLINE.
    tx_online = 0; resync_req = 1;
    step();
    resync_req = 0;
    chk("drop_rsq_sb32", 8'(obs(0)), 8'd0);
    chk("drop_rsq_sb3", 8'(obs(1)), 8'd0);

    // Resync timing from a fresh ONLINE, then reset in ONLINE.
    drive(0, 1, 1, 4, 0);
    step();
    wait_up(g);
    chk("bringup_beats", 8'(g), 8'd32);
    resync_req = 1;
    step();
    resync_req = 0;
    wait_up(g);
    chk("resync_beats", 8'(g), 8'd32);
    rst_wr = 1;
    step();
    rst_wr = 0;
    chk("rst_online", 8'(obs(0)), 8'd0);

    // Randomized traffic, slowly toggling tx_online so ONLINE is reached often.
    drive(0, 1, 1, 4, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(149) == 0) tx_online = ~tx_online;
      rst_wr           = ($urandom_range(499) == 0);
      resync_req       = ($urandom_range(59) == 0);
      m_gen2_mode      = 1'($urandom_range(1));
      cfg_stb_interval = 8'($urandom_range(9));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lpif_tx_stb_mrk_seq.md
Name: lpif_tx_stb_mrk_seq

Overview:
- TX-side link sequencer for the LPIF x4 asym2 full-rate concat datapath. It generates the per-beat strobe (PHY bit 1 in Gen2) and marker (PHY bit 77 in Gen2) userbits.
- It sequences link bring-up OFFLINE -> SYNC -> ONLINE and tells the logic-link side when downstream data may advance.
- It sits between the link-layer control and the concat block's tx_stb_userbit / tx_mrk_userbit / tx_online inputs, in the clk_wr domain.

Parameters:
- STB_W, 8, width of cfg_stb_interval and of the strobe counter.
- MRK_PERIOD, 2, Gen2 beats per marker group (asym2 = 2); must be >= 1.
- SYNC_BEATS, 32, minimum beats spent in SYNC before ONLINE; >= 1.
- SYNC_W, 8, width of the sync beat counter; must satisfy 2**SYNC_W > SYNC_BEATS.

Ports:
- clk_wr  input  1  TX clock; all logic is on its rising edge.
- rst_wr  input  1  synchronous, active-high reset.
- tx_online  input  1  link-layer request to bring the TX link up; level.
- m_gen2_mode  input  1  1 = Gen2 marker cadence, 0 = Gen1; sampled only on SYNC entry.
- cfg_stb_interval  input  STB_W  beats between strobes; value 0 is treated as 1; sampled only on SYNC entry.
- resync_req  input  1  single-cycle pulse; forces re-sync from ONLINE.
- tx_stb_userbit  output  1  strobe userbit to the concat block.
- tx_mrk_userbit  output  1  marker userbit, drives bit [0] of the concat marker bus.
- tx_link_up  output  1  high only in ONLINE.
- tx_pop_en  output  1  downstream data may advance this beat; equals tx_link_up.
- seq_state  output  2  0 = OFFLINE, 1 = SYNC, 2 = ONLINE; 3 is never produced.

Behaviour:
- Reset: while rst_wr = 1 at a clock edge, the next state is OFFLINE, all counters are 0, and every output is 0.
- Reset taking effect mid-SYNC or mid-ONLINE gives the same result on the following cycle.
- All outputs are a Moore decode of registered state and counters; there is no combinational path from any input to any output.
- In OFFLINE, all outputs are 0 and the counters are held at 0.
- OFFLINE -> SYNC when tx_online = 1 is sampled. On that edge:
  - stb_cnt, mrk_cnt and sync_cnt clear to 0.
  - gen2_q <= m_gen2_mode.
  - intv_q <= max(cfg_stb_interval, 1).
- Latency: tx_online sampled high at edge N gives seq_state = 1 and tx_stb_userbit = 1 in the cycle after edge N.
- Counters, active in SYNC and ONLINE:
  - stb_cnt increments and wraps to 0 when stb_cnt = intv_q - 1.
  - tx_stb_userbit = (stb_cnt == 0).
  - mrk_cnt wraps at mp - 1, where mp = gen2_q ? MRK_PERIOD : 1.
  - tx_mrk_userbit = (mrk_cnt == mp - 1), i.e. the last beat of each group. With Gen1 or MRK_PERIOD = 1 the marker is high every beat.
  - sync_cnt increments in SYNC and saturates at SYNC_BEATS - 1.
- SYNC -> ONLINE when sync_cnt == SYNC_BEATS - 1 and mrk_cnt == mp - 1 in the same cycle. The first ONLINE beat therefore has mrk_cnt = 0.
- stb_cnt and mrk_cnt continue without reset across SYNC -> ONLINE.
- ONLINE -> SYNC on resync_req = 1 with tx_online = 1. All counters clear and the config registers are re-sampled, exactly as on OFFLINE -> SYNC.
- resync_req is ignored outside ONLINE.
- SYNC or ONLINE -> OFFLINE whenever tx_online = 0 is sampled. This has priority over resync_req and over the SYNC -> ONLINE transition.
- Changes to cfg_stb_interval or m_gen2_mode while in SYNC or ONLINE have no effect until the next SYNC entry.

Test Plan:
- Reset, then tx_online = 1 held with cfg_stb_interval = 4, Gen2, MRK_PERIOD = 2, SYNC_BEATS = 32:
  - SYNC starts 1 cycle after the sampling edge.
  - Strobe is high on beats 0, 4, 8, ...
  - Marker is high on odd beats.
  - tx_link_up rises on beat 32, and that beat has marker = 0.
- SYNC_BEATS = 3, MRK_PERIOD = 2: ONLINE entry waits for a group boundary. SYNC lasts 4 beats, and the first ONLINE beat has marker = 0.
- cfg_stb_interval = 0: strobe is high every beat in both SYNC and ONLINE. Gen1 (m_gen2_mode = 0): marker is high every beat.
- In ONLINE, pulse resync_req: the next cycle has seq_state = 1, tx_link_up = 0 and strobe = 1, and ONLINE returns after 32 beats.
- Drop tx_online mid-SYNC, and separately in ONLINE in the same cycle as resync_req: the next cycle has seq_state = 0 and all outputs 0.
- Assert rst_wr in ONLINE for 1 cycle: all outputs are 0 on the next cycle. Change cfg_stb_interval from 4 to 7 during ONLINE: the strobe spacing stays 4 until the next re-sync, then becomes 7.
